// File: rtl/screen_state_ctrl.sv
// Screen sequencer: TITLE/PLAY/GAMEOVER/WIN tracking, press-start blink, end-screen hold,
// and a registered logo pixel merged from the matcher hit flags.
module screen_state_ctrl #(
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       player_dead,
  input  logic       all_enemies_dead,
  input  logic       is_galaga,
  input  logic       is_gameover,
  input  logic       is_press_start,
  input  logic       is_you_win,
  output logic [1:0] state,
  output logic       game_active,
  output logic       game_reset,
  output logic       is_logo,
  output logic [7:0] logo_r,
  output logic [7:0] logo_g,
  output logic [7:0] logo_b
);

  typedef enum logic [1:0] {
    TITLE    = 2'd0,
    PLAY     = 2'd1,
    GAMEOVER = 2'd2,
    WIN      = 2'd3
  } state_t;

  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);
  localparam logic [7:0] HOLD_MAX   = 8'(HOLD_FRAMES);

  state_t      cur, nxt;
  logic        f1, f2, f3, k1, k2, k3;
  logic        frame_tick, start_press;
  logic        enter_title, enter_end;
  logic [5:0]  blink_cnt;
  logic        blink_on;
  logic [7:0]  hold_cnt;
  logic        pix_en;
  logic [23:0] pix_rgb;

  assign state = cur;

  // Third flop of each chain turns the synchronized level into a one-cycle rising-edge pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {f1, f2, f3} <= 3'b000;
      {k1, k2, k3} <= 3'b000;
    end else begin
      {f1, f2, f3} <= {frame_clk, f1, f2};
      {k1, k2, k3} <= {start_key, k1, k2};
    end
  end

  assign frame_tick  = f2 & ~f3;
  assign start_press = k2 & ~k3;

  always_comb begin
    nxt = cur;
    case (cur)
      TITLE:         if (start_press) nxt = PLAY;
      PLAY: begin
        if (player_dead)           nxt = GAMEOVER;
        else if (all_enemies_dead) nxt = WIN;
      end
      GAMEOVER, WIN: if (start_press && hold_cnt == HOLD_MAX) nxt = TITLE;
      default:       nxt = TITLE;
    endcase
  end

  assign enter_title = (nxt == TITLE) && (cur != TITLE);
  assign enter_end   = (cur == PLAY) && ((nxt == GAMEOVER) || (nxt == WIN));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur         <= TITLE;
      game_active <= 1'b0;
      game_reset  <= 1'b0;
    end else begin
      cur         <= nxt;
      game_active <= (nxt == PLAY);
      game_reset  <= (cur == TITLE) && (nxt == PLAY);
    end
  end

  // Entry clears take precedence over a coincident frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt <= 6'd0;
      blink_on  <= 1'b1;
      hold_cnt  <= 8'd0;
    end else begin
      if (enter_title) begin
        blink_cnt <= 6'd0;
        blink_on  <= 1'b1;
      end else if (cur == TITLE && frame_tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= 6'd0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 6'd1;
        end
      end
      if (enter_end) begin
        hold_cnt <= 8'd0;
      end else if ((cur == GAMEOVER || cur == WIN) && frame_tick && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    pix_en  = 1'b0;
    pix_rgb = 24'h000000;
    case (cur)
      TITLE: begin
        if (is_galaga) begin
          pix_en  = 1'b1;
          pix_rgb = 24'hFF0000;
        end else if (is_press_start && blink_on) begin
          pix_en  = 1'b1;
          pix_rgb = 24'hFFFFFF;
        end
      end
      GAMEOVER: if (is_gameover) begin
        pix_en  = 1'b1;
        pix_rgb = 24'hFF0000;
      end
      WIN: if (is_you_win) begin
        pix_en  = 1'b1;
        pix_rgb = 24'hFFFF00;
      end
      default: ;
    endcase
  end

  // One register stage on the pixel path; DrawX/DrawY upstream are delayed to match.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_logo <= 1'b0;
      {logo_r, logo_g, logo_b} <= 24'h000000;
    end else begin
      is_logo <= pix_en;
      {logo_r, logo_g, logo_b} <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Bench for screen_state_ctrl: directed scenario sequence with randomized pixels, frame rate
// and game events, checked every cycle against a frame-counting screen model.
module tb_screen_state_ctrl;

  localparam int BLINK = 30;
  localparam int HOLD  = 120;

  logic       Clk, Reset_n, frame_clk, start_key, player_dead, all_enemies_dead;
  logic       is_galaga, is_gameover, is_press_start, is_you_win;
  logic [1:0] state;
  logic       game_active, game_reset, is_logo;
  logic [7:0] logo_r, logo_g, logo_b;

  screen_state_ctrl #(.BLINK_FRAMES(BLINK), .HOLD_FRAMES(HOLD)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start_key(start_key),
    .player_dead(player_dead), .all_enemies_dead(all_enemies_dead),
    .is_galaga(is_galaga), .is_gameover(is_gameover), .is_press_start(is_press_start),
    .is_you_win(is_you_win), .state(state), .game_active(game_active),
    .game_reset(game_reset), .is_logo(is_logo), .logo_r(logo_r), .logo_g(logo_g),
    .logo_b(logo_b)
  );

  // Clock / watchdog
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: screen, frames counted since entering TITLE / an end screen, input sample history.
  int total = 0;
  int bad   = 0;
  int m_state, m_title_frames, m_end_frames;
  bit m_pulse, exp_logo;
  logic [23:0] exp_rgb;
  bit fh[$], kh[$];
  bit frame_run;
  int frame_half, frame_ph;

  function automatic bit model_blink_on();
    return ((m_title_frames / BLINK) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pulse = 0; m_title_frames = 0; m_end_frames = 0;
    exp_logo = 0; exp_rgb = 24'h0;
    fh = '{0, 0, 0};
    kh = '{0, 0, 0};
  endtask

  task automatic model_edge();
    bit tick, press, done;
    int prev;
    // An input rising edge acts on the third Clk edge that sees it high.
    tick  = fh[1] && !fh[2];
    press = kh[1] && !kh[2];
    fh.push_front(frame_clk); void'(fh.pop_back());
    kh.push_front(start_key); void'(kh.pop_back());
    exp_logo = 0; exp_rgb = 24'h0;
    if (m_state == 0 && is_galaga)                                begin exp_logo = 1; exp_rgb = 24'hFF0000; end
    else if (m_state == 0 && is_press_start && model_blink_on())  begin exp_logo = 1; exp_rgb = 24'hFFFFFF; end
    else if (m_state == 2 && is_gameover)                         begin exp_logo = 1; exp_rgb = 24'hFF0000; end
    else if (m_state == 3 && is_you_win)                          begin exp_logo = 1; exp_rgb = 24'hFFFF00; end
    done = (m_end_frames >= HOLD);
    if (tick && m_state == 0) m_title_frames++;
    if (tick && m_state >= 2) m_end_frames++;
    prev = m_state;
    m_pulse = 0;
    case (prev)
      0: if (press) begin m_state = 1; m_pulse = 1; end
      1: if (player_dead) m_state = 2; else if (all_enemies_dead) m_state = 3;
      default: if (press && done) begin m_state = 0; m_title_frames = 0; end
    endcase
    if (prev == 1 && m_state != 1) m_end_frames = 0;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("state", 32'(state), 32'(m_state));
    chk("game_active", 32'(game_active), 32'(m_state == 1));
    chk("game_reset", 32'(game_reset), 32'(m_pulse));
    chk("is_logo", 32'(is_logo), 32'(exp_logo));
    chk("rgb", 32'({logo_r, logo_g, logo_b}), 32'(exp_rgb));
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge Clk);
    if (Reset_n) model_edge();
    #1;
    check_outputs();
    if (frame_run) begin
      frame_ph++;
      if (frame_ph >= frame_half) begin
        frame_ph  = 0;
        frame_clk = ~frame_clk;
      end
    end
  endtask

  task automatic rand_pix();
    is_galaga      = ($urandom_range(0, 3) == 0);
    is_press_start = ($urandom_range(0, 1) == 0);
    is_gameover    = ($urandom_range(0, 1) == 0);
    is_you_win     = ($urandom_range(0, 1) == 0);
  endtask

  task automatic run_until_state(input int target, input int budget, input string tag);
    int n = 0;
    while (m_state != target && n < budget) begin
      rand_pix();
      cycle();
      n++;
    end
    chk(tag, 32'(state), 32'(target));
  endtask

  task automatic run_frames(input int frames);
    repeat (frames * 2 * frame_half) begin
      rand_pix();
      cycle();
    end
  endtask

  task automatic press_start();
    start_key = 1'b1;
    repeat (5) begin rand_pix(); cycle(); end
    start_key = 1'b0;
    repeat (5) begin rand_pix(); cycle(); end
  endtask

  // Stimulus
  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; start_key = 1'b0;
    player_dead = 1'b0; all_enemies_dead = 1'b0;
    is_galaga = 1'b0; is_gameover = 1'b0; is_press_start = 1'b0; is_you_win = 1'b0;
    frame_run = 0; frame_ph = 0; frame_half = $urandom_range(3, 6);
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check_outputs();
    @(negedge Clk);
    Reset_n = 1'b1;

    // TITLE blink with press-start held, galaga overlapping now and then
    frame_run = 1;
    repeat (65 * 2 * frame_half) begin
      is_press_start = 1'b1;
      is_galaga      = ($urandom_range(0, 7) == 0);
      is_gameover    = ($urandom_range(0, 1) == 0);
      is_you_win     = ($urandom_range(0, 1) == 0);
      cycle();
    end

    // Start, key stays held across PLAY, the death and the whole hold period
    start_key = 1'b1;
    run_until_state(1, 10, "enter_play");
    run_frames(3);
    player_dead = 1'b1; all_enemies_dead = 1'b1;
    cycle();
    player_dead = 1'b0; all_enemies_dead = 1'b0;
    chk("both_dead_gameover", 32'(state), 32'd2);
    run_frames(HOLD + 10);
    chk("held_key_no_exit", 32'(state), 32'd2);
    start_key = 1'b0;
    repeat (5) begin rand_pix(); cycle(); end
    start_key = 1'b1;
    run_until_state(0, 10, "gameover_to_title");
    start_key = 1'b0;

    // WIN: early press dropped, late press accepted
    run_frames(2);
    start_key = 1'b1;
    run_until_state(1, 10, "enter_play2");
    start_key = 1'b0;
    run_frames(2);
    all_enemies_dead = 1'b1;
    cycle();
    all_enemies_dead = 1'b0;
    chk("enter_win", 32'(state), 32'd3);
    while (m_end_frames < 50) begin rand_pix(); cycle(); end
    press_start();
    chk("early_press_dropped", 32'(state), 32'd3);
    begin
      int n = 0;
      while (m_end_frames < HOLD && n < 4000) begin rand_pix(); cycle(); n++; end
      chk("hold_reached", 32'(m_end_frames >= HOLD), 32'd1);
    end
    start_key = 1'b1;
    run_until_state(0, 10, "win_to_title");
    start_key = 1'b0;
    is_galaga = 1'b0; is_press_start = 1'b1;
    cycle(); cycle();
    chk("blink_on_after_title", 32'(is_logo), 32'd1);

    // Randomized play
    repeat (2500) begin
      rand_pix();
      if ($urandom_range(0, 15) == 0) start_key = ~start_key;
      player_dead      = ($urandom_range(0, 59) == 0);
      all_enemies_dead = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 300) == 0) frame_half = $urandom_range(2, 6);
      cycle();
    end
    player_dead = 1'b0; all_enemies_dead = 1'b0; start_key = 1'b0;
    repeat (5) begin rand_pix(); cycle(); end
    if (m_state != 0) begin
      while (m_end_frames < HOLD) begin rand_pix(); cycle(); end
      start_key = 1'b1;
      run_until_state(0, 10, "random_back_to_title");
      start_key = 1'b0;
      repeat (5) begin rand_pix(); cycle(); end
    end

    // Asynchronous reset mid-PLAY, key held through release
    start_key = 1'b1;
    run_until_state(1, 10, "enter_play3");
    run_frames(2);
    @(posedge Clk);
    model_edge();
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) cycle();
    @(negedge Clk);
    Reset_n = 1'b1;
    run_until_state(1, 8, "held_key_after_reset");
    start_key = 1'b0;
    repeat (20) begin rand_pix(); cycle(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_state_ctrl.md
# screen_state_ctrl

Top-level screen sequencer sitting directly downstream of the logo matchers (`galaga`, `gameover`, `press_start` and `you_win`). It tracks which screen is showing: TITLE, PLAY, GAMEOVER or WIN. It blinks the press-start text on a frame count and enforces a minimum display time on the end screens. It merges the matcher hit flags into one registered logo pixel (enable plus RGB) for the colour mapper, and issues the start-of-game pulse to the game logic.

## Interface
Parameters:
- BLINK_FRAMES, 30: frames per press-start on/off half-period.
- HOLD_FRAMES, 120: frames an end screen ignores start before accepting it.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vsync-derived frame clock; asynchronous to Clk, rising edge = new frame.
- start_key  in  1  start button level; asynchronous, active-high.
- player_dead  in  1  level from game logic; sampled in PLAY only.
- all_enemies_dead  in  1  level from game logic; sampled in PLAY only.
- is_galaga, is_gameover, is_press_start, is_you_win  in  1 each  matcher hits for the current DrawX/DrawY.
- state  out  2  TITLE=0, PLAY=1, GAMEOVER=2, WIN=3.
- game_active  out  1  high while state==PLAY.
- game_reset  out  1  one-Clk pulse on the TITLE→PLAY transition.
- is_logo  out  1  current pixel belongs to a visible logo.
- logo_r, logo_g, logo_b  out  8 each  logo colour; 0 when is_logo=0.

## Operation
- Input conditioning: frame_clk and start_key each pass through a 2-flop synchronizer and a third edge register.
  - frame_tick = s2 & ~s3.
  - start_press = k2 & ~k3.
  - Each is one Clk cycle wide, one per rising edge.
- FSM:
  - TITLE: start_press → PLAY, with game_reset=1 for that cycle.
  - PLAY: player_dead → GAMEOVER; all_enemies_dead → WIN; both in the same cycle → GAMEOVER (priority).
  - GAMEOVER / WIN: start_press while hold_cnt==HOLD_FRAMES → TITLE. Presses before that are dropped, not queued.
- Blink counter, 6 bits (active in TITLE):
  - On frame_tick: if blink_cnt==BLINK_FRAMES-1, set blink_cnt=0 and toggle blink_on; else blink_cnt+1.
  - Any entry into TITLE sets blink_cnt=0 and blink_on=1.
- Hold counter, 8 bits:
  - Cleared on entry to GAMEOVER or WIN.
  - Increments on frame_tick, saturating at HOLD_FRAMES.
- Pixel select (combinational from state and the is_* inputs, then registered):
  - TITLE: is_galaga → FF/00/00. Else is_press_start & blink_on → FF/FF/FF. Galaga wins on overlap.
  - GAMEOVER: is_gameover → FF/00/00.
  - WIN: is_you_win → FF/FF/00.
  - PLAY, or no qualifying hit: is_logo=0, RGB=0.
  - Hits not belonging to the current state are ignored.

## Timing
- Reset (async assert, synchronous release on the next Clk):
  - state=TITLE, game_active=0, game_reset=0, is_logo=0, RGB=0.
  - blink_on=1, blink_cnt=0, hold_cnt=0.
  - All synchronizer flops=0, so a key already held at reset release yields one start_press about 3 cycles later.
- frame_clk or start_key rising edge → tick/press asserted on the 3rd Clk edge after the input is stable high.
- State transition registered: state, game_active and game_reset update on the Clk edge that samples the cause. game_reset is high exactly one cycle.
- Pixel path latency: is_* inputs to is_logo/RGB is exactly 1 Clk. Upstream DrawX/DrawY must be delayed to match.
- Simultaneous frame_tick and state entry: the entry clear wins; the counter holds 0 that cycle.
- Reset asserted mid-game: immediate return to TITLE, no game_reset pulse.

## Test plan
- Reset, then a start_key rising edge → state 0→1 about 3 Clk later, game_reset high exactly 1 cycle, game_active=1.
- TITLE, is_press_start=1 held, 60 frame_clk edges → is_logo=1 for frames 0–29, 0 for 30–59, then 1 again. is_galaga=1 overrides with FF/00/00.
- PLAY with player_dead and all_enemies_dead raised in the same cycle → state=2. is_you_win=1 gives is_logo=0; is_gameover=1 gives FF/00/00 one Clk later.
- WIN: start pressed at frame 50 → stays 3. After 120 frame ticks, a press → state=0 with blink_on=1.
- start_key held high across the whole PLAY→GAMEOVER→hold period → no transition to TITLE until it is released and pressed again.
- Reset_n pulsed low mid-PLAY, asynchronously between Clk edges → outputs go to reset values before the next Clk edge; state=0.
